// File: rtl/ebc_scan_controller_if.sv
// Bus between the scan controller, the pixel-array request lines and the event stream.
// Event stream: an event transfers on a rising edge where evt_valid_o && evt_ready_i; once valid is
// raised, x/y/ts hold stable and valid stays high until that edge.
interface ebc_scan_controller_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int X_W  = 3,
    parameter int Y_W  = 3,
    parameter int TS_W = 16
);
    logic [ROWS-1:0] row_req_i;
    logic [COLS-1:0] col_req_i;
    logic [ROWS-1:0] row_sel_o;
    logic [COLS-1:0] col_ack_o;
    logic            evt_valid_o;
    logic            evt_ready_i;
    logic [X_W-1:0]  evt_x_o;
    logic [Y_W-1:0]  evt_y_o;
    logic [TS_W-1:0] evt_ts_o;

    modport master (
        input  row_req_i, col_req_i, evt_ready_i,
        output row_sel_o, col_ack_o, evt_valid_o, evt_x_o, evt_y_o, evt_ts_o
    );

    modport slave (
        output row_req_i, col_req_i, evt_ready_i,
        input  row_sel_o, col_ack_o, evt_valid_o, evt_x_o, evt_y_o, evt_ts_o
    );
endinterface

// File: rtl/ebc_scan_controller.sv
// Event-camera readout sequencer: round-robin row grant, column snapshot, one timestamped
// event per requesting column, pixel ack once the event is accepted downstream.
module ebc_scan_controller #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int X_W  = 3,
    parameter int Y_W  = 3,
    parameter int TS_W = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    ebc_scan_controller_if.master bus,
    output logic                  busy_o,
    output logic [2:0]            state_o
);
    typedef enum logic [2:0] {IDLE, SETTLE, COL_GRANT, EMIT, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [ROWS-1:0] row_sel_q, row_sel_d;
    logic [ROWS-1:0] row_mask_q, row_mask_d;
    logic [Y_W-1:0]  row_q, row_d;
    logic [COLS-1:0] pend_q, pend_d, pend_rest;
    logic [COLS-1:0] col_ack_q, col_ack_d;
    logic            evt_valid_q, evt_valid_d;
    logic [X_W-1:0]  evt_x_q, evt_x_d;
    logic [Y_W-1:0]  evt_y_q, evt_y_d;
    logic [TS_W-1:0] evt_ts_q, evt_ts_d;
    logic [TS_W-1:0] ts_snap_q, ts_snap_d;
    logic [TS_W-1:0] ts_cnt_q;
    logic            busy_q;
    logic [ROWS-1:0] masked_req;
    logic [Y_W-1:0]  grant_row;
    logic [X_W-1:0]  next_col;

    function automatic logic [Y_W-1:0] lsb_row(input logic [ROWS-1:0] v);
        lsb_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) if (v[i]) lsb_row = Y_W'(i);
    endfunction

    function automatic logic [X_W-1:0] lsb_col(input logic [COLS-1:0] v);
        lsb_col = '0;
        for (int i = COLS - 1; i >= 0; i--) if (v[i]) lsb_col = X_W'(i);
    endfunction

    always_comb begin
        state_d     = state_q;
        row_sel_d   = row_sel_q;
        row_mask_d  = row_mask_q;
        row_d       = row_q;
        pend_d      = pend_q;
        pend_rest   = pend_q;
        col_ack_d   = '0;
        evt_valid_d = evt_valid_q;
        evt_x_d     = evt_x_q;
        evt_y_d     = evt_y_q;
        evt_ts_d    = evt_ts_q;
        ts_snap_d   = ts_snap_q;
        // Rows above the last served one win; fall back to the lowest row to wrap around.
        masked_req  = bus.row_req_i & row_mask_q;
        grant_row   = (|masked_req) ? lsb_row(masked_req) : lsb_row(bus.row_req_i);
        next_col    = lsb_col(pend_q);

        case (state_q)
            IDLE: begin
                if (enable_i && (|bus.row_req_i)) begin
                    row_sel_d = ROWS'(1) << grant_row;
                    row_d     = grant_row;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                pend_d    = bus.col_req_i;
                ts_snap_d = ts_cnt_q;
                state_d   = (|bus.col_req_i) ? COL_GRANT : RELEASE;
            end
            COL_GRANT: begin
                evt_x_d     = next_col;
                evt_y_d     = row_q;
                evt_ts_d    = ts_snap_q;
                evt_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (bus.evt_ready_i) begin
                    pend_rest   = pend_q & ~(COLS'(1) << evt_x_q);
                    pend_d      = pend_rest;
                    evt_valid_d = 1'b0;
                    col_ack_d   = COLS'(1) << evt_x_q;
                    // Dropping enable abandons the rest of the snapshot; those pixels keep requesting.
                    state_d     = ((|pend_rest) && enable_i) ? COL_GRANT : RELEASE;
                end
            end
            RELEASE: begin
                row_sel_d  = '0;
                row_mask_d = {ROWS{1'b1}} << (32'(row_q) + 32'd1);
                pend_d     = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            row_sel_q   <= '0;
            row_mask_q  <= {ROWS{1'b1}};
            row_q       <= '0;
            pend_q      <= '0;
            col_ack_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_x_q     <= '0;
            evt_y_q     <= '0;
            evt_ts_q    <= '0;
            ts_snap_q   <= '0;
            ts_cnt_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_sel_q   <= row_sel_d;
            row_mask_q  <= row_mask_d;
            row_q       <= row_d;
            pend_q      <= pend_d;
            col_ack_q   <= col_ack_d;
            evt_valid_q <= evt_valid_d;
            evt_x_q     <= evt_x_d;
            evt_y_q     <= evt_y_d;
            evt_ts_q    <= evt_ts_d;
            ts_snap_q   <= ts_snap_d;
            ts_cnt_q    <= ts_cnt_q + TS_W'(1);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.row_sel_o   = row_sel_q;
    assign bus.col_ack_o   = col_ack_q;
    assign bus.evt_valid_o = evt_valid_q;
    assign bus.evt_x_o     = evt_x_q;
    assign bus.evt_y_o     = evt_y_q;
    assign bus.evt_ts_o    = evt_ts_q;
    assign busy_o          = busy_q;
    assign state_o         = state_q;
endmodule
